// File: rtl/sram_arbiter.sv
// Two-port arbiter for a single-ported async SRAM with a registered
// SETUP/STROBE/HOLD access sequence and alternating tie-break.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_x, we_x          request and write-enable from requester A / B
//   addr_x, wdata_x      request address and write data (8 bits)
//   ack_x, rdata_x       one-cycle completion pulse and held read data
//   busy                 high whenever an access is in flight
//   sram_cs, sram_wr     chip select and write strobe (active-high)
//   sram_rd              read strobe (active-low)
//   sram_addr, sram_din  address and write data to the SRAM
//   sram_dout            read data from the SRAM
module sram_arbiter #(
  parameter int STROBE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       we_a,
  input  logic       we_b,
  input  logic [7:0] addr_a,
  input  logic [7:0] addr_b,
  input  logic [7:0] wdata_a,
  input  logic [7:0] wdata_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b,
  output logic       busy,
  output logic       sram_cs,
  output logic       sram_wr,
  output logic       sram_rd,
  output logic [7:0] sram_addr,
  output logic [7:0] sram_din,
  input  logic [7:0] sram_dout
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  localparam logic [3:0] LAST = 4'(STROBE_CYC - 1);

  state_t     state;
  state_t     state_n;
  logic [3:0] cnt;
  logic       last_b;
  logic       gnt_b;
  logic       op_we;
  logic       grant;
  logic       win_b;
  logic       strobe_n;
  logic       rd_done;

  // B wins if it is alone, or on a tie when A was the last grant.
  always_comb begin
    state_n = state;
    grant   = 1'b0;
    win_b   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_a || req_b) begin
          state_n = SETUP;
          grant   = 1'b1;
          win_b   = req_b && (!req_a || !last_b);
        end
      end
      SETUP:  state_n = STROBE;
      STROBE: if (cnt == LAST) state_n = HOLD;
      HOLD:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign strobe_n = (state_n == STROBE);
  assign rd_done  = (state == STROBE) && (cnt == LAST) && !op_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state == STROBE) ? cnt + 4'd1 : 4'd0;
    end
  end

  // Request capture at grant; ignored afterwards until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_b    <= 1'b1;
      gnt_b     <= 1'b0;
      op_we     <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
    end else if (grant) begin
      last_b    <= win_b;
      gnt_b     <= win_b;
      op_we     <= win_b ? we_b : we_a;
      sram_addr <= win_b ? addr_b : addr_a;
      sram_din  <= win_b ? wdata_b : wdata_a;
    end
  end

  // Outputs are registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      sram_cs <= 1'b0;
      sram_wr <= 1'b0;
      sram_rd <= 1'b1;
      ack_a   <= 1'b0;
      ack_b   <= 1'b0;
    end else begin
      busy    <= (state_n != IDLE);
      sram_cs <= (state_n != IDLE);
      sram_wr <= strobe_n && op_we;
      sram_rd <= !(strobe_n && !op_we);
      ack_a   <= (state_n == HOLD) && !gnt_b;
      ack_b   <= (state_n == HOLD) && gnt_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else if (rd_done) begin
      if (gnt_b) rdata_b <= sram_dout;
      else       rdata_a <= sram_dout;
    end
  end

endmodule
